// File: rtl/k2red_pkg.sv
// Shared definitions for the K2-RED digit-serial multiplier: sizing helpers,
// default configuration and the controller state type.
package k2red_pkg;

  localparam int LOG_Q_DEF = 32;
  localparam int LOG_L_DEF = 4;
  localparam int DIGIT_DEF = 8;

  function automatic int n_dig_f(input int log_q, input int digit);
    return log_q / digit;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width_f(input int n_dig);
    return (n_dig > 1) ? $clog2(n_dig) : 1;
  endfunction

  function automatic int prod_width_f(input int log_q);
    return 2 * log_q;
  endfunction

  localparam int N_DIG  = n_dig_f(LOG_Q_DEF, DIGIT_DEF);
  localparam int CNT_W  = cnt_width_f(N_DIG);
  localparam int PROD_W = prod_width_f(LOG_Q_DEF);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/k2red_digit_mac.sv
// One digit-serial step: multiply the full multiplicand by one digit of the
// multiplier, align it to its digit position and add it into the running sum.
module k2red_digit_mac
  import k2red_pkg::*;
#(
  parameter int LOG_Q = LOG_Q_DEF,
  parameter int DIGIT = DIGIT_DEF,
  parameter int CNT_W = cnt_width_f(n_dig_f(LOG_Q_DEF, DIGIT_DEF))
) (
  input  logic [2*LOG_Q-1:0] acc,
  input  logic [LOG_Q-1:0]   a,
  input  logic [DIGIT-1:0]   digit,
  input  logic [CNT_W-1:0]   k,
  output logic [2*LOG_Q-1:0] sum
);

  localparam int P = 2 * LOG_Q;

  logic [P-1:0] partial;

  assign partial = P'(a) * P'(digit);
  assign sum     = acc + (partial << (k * DIGIT));

endmodule

// File: rtl/k2red_mul_ds.sv
// Digit-serial a*b multiplier feeding the K2-RED reducer; Q and l1..l3 travel
// with the product. Define K2RED_MUL_RANGE_CHECK_EN to flag a >= Q or b >= Q.
module k2red_mul_ds
  import k2red_pkg::*;
#(
  parameter int LOG_Q = LOG_Q_DEF,
  parameter int LOG_L = LOG_L_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LOG_Q-1:0]     a,
  input  logic [LOG_Q-1:0]     b,
  input  logic [LOG_Q-1:0]     Q,
  input  logic [LOG_L-1:0]     l1,
  input  logic [LOG_L-1:0]     l2,
  input  logic [LOG_L-1:0]     l3,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [2*LOG_Q-1:0]   A,
  output logic [LOG_Q-1:0]     Q_out,
  output logic [LOG_L-1:0]     l1_out,
  output logic [LOG_L-1:0]     l2_out,
  output logic [LOG_L-1:0]     l3_out,
  output logic                 valid_out,
  output logic                 err_out
);

  localparam int ND     = n_dig_f(LOG_Q, DIGIT);
  localparam int CW     = cnt_width_f(ND);
  localparam int PW     = prod_width_f(LOG_Q);

  state_t            state_reg, state_next;
  logic [LOG_Q-1:0]  a_reg, b_reg, q_reg;
  logic [LOG_L-1:0]  l1_reg, l2_reg, l3_reg;
  logic [PW-1:0]     acc_reg;
  logic [CW-1:0]     k_reg;
  logic [DIGIT-1:0]  digit;
  logic [PW-1:0]     mac_sum;
  logic              accept;
  logic              last;

  always_comb begin
    state_next = state_reg;
    ready_in   = (state_reg == IDLE);
    accept     = valid_in && (state_reg == IDLE);
    last       = (state_reg == BUSY) && (k_reg == CW'(ND - 1));
    if (accept)
      state_next = BUSY;
    else if (last)
      state_next = IDLE;
  end

  assign digit = b_reg[k_reg * DIGIT +: DIGIT];

  k2red_digit_mac #(
    .LOG_Q (LOG_Q),
    .DIGIT (DIGIT),
    .CNT_W (CW)
  ) u_mac (
    .acc   (acc_reg),
    .a     (a_reg),
    .digit (digit),
    .k     (k_reg),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      l1_reg    <= '0;
      l2_reg    <= '0;
      l3_reg    <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      A         <= '0;
      Q_out     <= '0;
      l1_out    <= '0;
      l2_out    <= '0;
      l3_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_out <= 1'b0;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        q_reg   <= Q;
        l1_reg  <= l1;
        l2_reg  <= l2;
        l3_reg  <= l3;
        acc_reg <= '0;
        k_reg   <= '0;
      end else if (state_reg == BUSY) begin
        acc_reg <= mac_sum;
        k_reg   <= last ? '0 : k_reg + CW'(1);
        // The final partial sum goes straight to A so the pulse lands one cycle earlier.
        if (last) begin
          A         <= mac_sum;
          Q_out     <= q_reg;
          l1_out    <= l1_reg;
          l2_out    <= l2_reg;
          l3_out    <= l3_reg;
          valid_out <= 1'b1;
        end
      end
    end
  end

`ifdef K2RED_MUL_RANGE_CHECK_EN
  logic err_hold_reg;
  logic err_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_hold_reg <= 1'b0;
      err_out_reg  <= 1'b0;
    end else begin
      if (accept)
        err_hold_reg <= (a >= Q) || (b >= Q);
      err_out_reg <= last ? err_hold_reg : 1'b0;
    end
  end

  assign err_out = err_out_reg;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_k2red_mul_ds.sv
// Directed bench for k2red_mul_ds: latency, product, sideband, back-to-back,
// busy-ignore, mid-operation reset and edge operands.
module tb_k2red_mul_ds;

  localparam int LOG_Q = 32;
  localparam int LOG_L = 4;
  localparam int LAT   = 4;

`ifdef K2RED_MUL_RANGE_CHECK_EN
  localparam logic RC_EN = 1'b1;
`else
  localparam logic RC_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LOG_Q-1:0]   a, b, Q;
  logic [LOG_L-1:0]   l1, l2, l3;
  logic               valid_in;
  logic               ready_in;
  logic [2*LOG_Q-1:0] A;
  logic [LOG_Q-1:0]   Q_out;
  logic [LOG_L-1:0]   l1_out, l2_out, l3_out;
  logic               valid_out;
  logic               err_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  k2red_mul_ds dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .Q         (Q),
    .l1        (l1),
    .l2        (l2),
    .l3        (l3),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .A         (A),
    .Q_out     (Q_out),
    .l1_out    (l1_out),
    .l2_out    (l2_out),
    .l3_out    (l3_out),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] qv,
                       input logic [3:0] x1, input logic [3:0] x2, input logic [3:0] x3);
    a  = av;
    b  = bv;
    Q  = qv;
    l1 = x1;
    l2 = x2;
    l3 = x3;
  endtask

  // Steps until valid_out is seen or the budget runs out; returns cycles stepped.
  task automatic wait_pulse(output int cycles);
    cycles = 0;
    while (valid_out !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] qv,
                        input logic [3:0] x1, input logic [3:0] x2, input logic [3:0] x3,
                        input logic [63:0] exp_a, input logic exp_err);
    int cyc;
    drive(av, bv, qv, x1, x2, x3);
    valid_in = 1'b1;
    chk({tag, "_ready_pre"}, 64'(ready_in), 64'd1);
    step();
    valid_in = 1'b0;
    chk({tag, "_ready_busy"}, 64'(ready_in), 64'd0);
    wait_pulse(cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
    chk({tag, "_A"}, A, exp_a);
    chk({tag, "_Q_out"}, 64'(Q_out), 64'(qv));
    chk({tag, "_l_out"}, 64'({l1_out, l2_out, l3_out}), 64'({x1, x2, x3}));
    chk({tag, "_err"}, 64'(err_out), 64'(exp_err));
    chk({tag, "_ready_done"}, 64'(ready_in), 64'd1);
    step();
    chk({tag, "_single_pulse"}, 64'(valid_out), 64'd0);
    chk({tag, "_A_hold"}, A, exp_a);
    $display("op %s a=%0h b=%0h A=%0h err=%0b latency=%0d", tag, av, bv, A, err_out, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0);
    step();
    step();
    chk("reset_A", A, 64'd0);
    chk("reset_Q_out", 64'(Q_out), 64'd0);
    chk("reset_l_out", 64'({l1_out, l2_out, l3_out}), 64'd0);
    chk("reset_valid", 64'(valid_out), 64'd0);
    chk("reset_err", 64'(err_out), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", 64'(ready_in), 64'd1);
    $display("reset released");

    // Small operands
    run_op("small", 32'd3, 32'd5, 32'h7FFE0001, 4'd1, 4'd2, 4'd3, 64'd15, 1'b0);

    // Full-scale operands, both exceed Q
    run_op("full", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFE0001, 4'd4, 4'd5, 4'd6,
           64'hFFFFFFFE00000001, RC_EN);

    // Back-to-back with valid_in held high
    drive(32'd2, 32'd7, 32'h7FFE0001, 4'd7, 4'd8, 4'd9);
    valid_in = 1'b1;
    step();
    drive(32'h10000, 32'h10000, 32'h12345678, 4'd10, 4'd11, 4'd12);
    wait_pulse(cyc);
    chk("b2b1_latency", 64'(cyc), 64'(LAT));
    chk("b2b1_A", A, 64'd14);
    chk("b2b1_l_out", 64'({l1_out, l2_out, l3_out}), 64'({4'd7, 4'd8, 4'd9}));
    chk("b2b1_Q_out", 64'(Q_out), 64'h7FFE0001);
    $display("op b2b1 A=%0h latency=%0d", A, cyc);
    step();
    valid_in = 1'b0;
    chk("b2b2_no_pulse", 64'(valid_out), 64'd0);
    wait_pulse(cyc);
    chk("b2b_interval", 64'(cyc + 1), 64'(LAT + 1));
    chk("b2b2_A", A, 64'h100000000);
    chk("b2b2_l_out", 64'({l1_out, l2_out, l3_out}), 64'({4'd10, 4'd11, 4'd12}));
    chk("b2b2_Q_out", 64'(Q_out), 64'h12345678);
    $display("op b2b2 A=%0h interval=%0d", A, cyc + 1);
    step();

    // valid_in during BUSY is ignored
    drive(32'd4, 32'd4, 32'h7FFE0001, 4'd1, 4'd1, 4'd1);
    valid_in = 1'b1;
    step();
    drive(32'd9, 32'd9, 32'h7FFE0001, 4'd2, 4'd2, 4'd2);
    wait_pulse(cyc);
    valid_in = 1'b0;
    chk("busy_latency", 64'(cyc), 64'(LAT));
    chk("busy_A", A, 64'd16);
    chk("busy_l_out", 64'({l1_out, l2_out, l3_out}), 64'({4'd1, 4'd1, 4'd1}));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_out === 1'b1) pulses++;
    end
    chk("busy_no_extra_pulse", 64'(pulses), 64'd0);
    chk("busy_A_hold", A, 64'd16);
    $display("op busy_ignore A=%0h extra_pulses=%0d", A, pulses);

    // Reset two cycles after accept aborts the operation
    drive(32'd123, 32'd456, 32'h7FFE0001, 4'd3, 4'd3, 4'd3);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_A", A, 64'd0);
    chk("abort_Q_out", 64'(Q_out), 64'd0);
    chk("abort_l_out", 64'({l1_out, l2_out, l3_out}), 64'd0);
    pulses = 0;
    step();
    if (valid_out === 1'b1) pulses++;
    step();
    if (valid_out === 1'b1) pulses++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid_out === 1'b1) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    chk("abort_A_still_0", A, 64'd0);
    $display("op abort pulses=%0d A=%0h", pulses, A);
    run_op("after_abort", 32'd6, 32'd7, 32'h7FFE0001, 4'd2, 4'd4, 4'd8, 64'd42, 1'b0);

    // Zero multiplicand, large multiplier
    run_op("zero_a", 32'd0, 32'hDEADBEEF, 32'h7FFE0001, 4'd15, 4'd0, 4'd15, 64'd0, RC_EN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
